fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_sync_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared frontend types: fetch-queue entry, reset PC default and fetch FSM states.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    IDLE
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO with occupancy count and a one-cycle clear.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy update; clear empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count and pointers alone define which words are valid.
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Overflow guard: a push into a full FIFO without a pop would lose data.
  always_ff @(posedge clk) begin
    if (rst && !clear) begin
      assert (!(push && full && !pop))
        else $error("sync_fifo: push while full");
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned I-memory requests under a credit
// limit, tracks in-flight PCs, drops responses made stale by a redirect and
// forwards surviving instructions into the fetch queue in order.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        fq_push_en,
  output logic [31:0] fq_instr,
  output logic [31:0] fq_pc,
  input  logic        fq_full
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  fetch_state_t state;
  fetch_state_t state_next;

  logic [31:0]  pc;
  logic [CW-1:0] drop_cnt;

  logic [31:0]  inflight_pc;
  logic         inflight_empty;
  logic         inflight_full;
  logic [CW-1:0] inflight_cnt;

  fetch_entry_t buf_wdata;
  fetch_entry_t buf_head;
  logic         buf_empty;
  logic         buf_full;
  logic [CW-1:0] buf_cnt;

  logic [CW:0]  outstanding;
  logic         credit_ok;
  logic         req_fire;
  logic         resp_take;
  logic         resp_stale;
  logic         buf_write;

  // Every accepted request either sits in the PC FIFO or in the response
  // buffer, so bounding their sum guarantees buffer space for each response.
  assign outstanding = {1'b0, inflight_cnt} + {1'b0, buf_cnt};
  assign credit_ok   = (outstanding < (CW+1)'(MAX_OUTSTANDING));

  assign req_fire   = imem_req_valid && imem_req_ready;
  // A response with no matching in-flight PC is a protocol error and is ignored.
  assign resp_take  = imem_resp_valid && !inflight_empty;
  assign resp_stale = redirect_valid || (drop_cnt != '0);
  assign buf_write  = resp_take && !resp_stale;

  assign buf_wdata     = '{instr: imem_resp_data, pc: inflight_pc};
  assign imem_req_addr = pc;
  assign fq_instr      = buf_head.instr;
  assign fq_pc         = buf_head.pc;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= BOOT;
    else      state <= state_next;
  end

  // FSM next state; leaving FETCH waits for a presented request to be accepted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_next = state;
    unique case (state)
      BOOT:    state_next = FETCH;
      FETCH:   if (!fetch_en && !(imem_req_valid && !imem_req_ready)) state_next = IDLE;
      IDLE:    if (fetch_en) state_next = FETCH;
      default: state_next = BOOT;
    endcase
  end

  // FSM outputs: request and fetch-queue push strobes.
  always_comb begin
    imem_req_valid = 1'b0;
    fq_push_en     = 1'b0;
    if (rst && state == FETCH && !redirect_valid && credit_ok) imem_req_valid = 1'b1;
    if (rst && !buf_empty && !fq_full && !redirect_valid)      fq_push_en     = 1'b1;
  end

  // Fetch PC and count of in-flight responses to discard after a redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc       <= RESET_PC & 32'hFFFF_FFFC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & 32'hFFFF_FFFC;
      // The response arriving this very cycle is already discarded; exclude it.
      drop_cnt <= inflight_cnt - CW'(resp_take);
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      if (resp_take && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // Protocol checks: orphan responses and credit violations.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(imem_resp_valid && inflight_empty))
        else $error("fetch_unit: response with no request in flight");
      assert (!(req_fire && inflight_full && !resp_take))
        else $error("fetch_unit: request accepted beyond in-flight capacity");
      assert (!(buf_write && buf_full && !fq_push_en))
        else $error("fetch_unit: response buffer overflow");
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_inflight_pc (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .push  (req_fire),
    .wdata (pc),
    .pop   (resp_take),
    .rdata (inflight_pc),
    .empty (inflight_empty),
    .full  (inflight_full),
    .count (inflight_cnt)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_buf (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (buf_write),
    .wdata (buf_wdata),
    .pop   (fq_push_en),
    .rdata (buf_head),
    .empty (buf_empty),
    .full  (buf_full),
    .count (buf_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural I-memory answers accepted
// requests after a programmable latency, expected pushes are queued by the
// stimulus and a monitor compares every fetch-queue push against them.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        fq_push_en;
  logic [31:0] fq_instr;
  logic [31:0] fq_pc;
  logic        fq_full = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC        (RST_PC),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .fq_push_en      (fq_push_en),
    .fq_instr        (fq_instr),
    .fq_pc           (fq_pc),
    .fq_full         (fq_full)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // Instruction word the memory model returns for an address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    lat      = 1;
  int    accepted = 0;
  int    limit    = 0;
  int    accept_cyc[logic [31:0]];

  // Respond to the oldest due request, then record this cycle's handshake.
  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
      end
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{imem_req_addr, cyc + lat});
        accepted++;
        accept_cyc[imem_req_addr] = cyc;
      end
    end
  end

  // Ready is offered only while the stimulus grants more requests.
  always @(posedge clk) begin
    #2;
    imem_req_ready = (accepted < limit);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  bit   lat_chk = 1'b0;
  int   pushes  = 0;

  // Monitor: every push must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst && fq_push_en) begin
      pushes++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_push: got pc %h, required no push", fq_pc);
      end else begin
        e = exp_q.pop_front();
        check("push_pc", fq_pc, e.pc);
        check("push_instr", fq_instr, e.instr);
        if (lat_chk) check("push_latency", 32'(cyc - accept_cyc[fq_pc]), 32'd2);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pcs(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      exp_q.push_back('{a, instr_of(a)});
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_accepted(input string name, input int target, input int budget);
    int k = 0;
    while (accepted < target && k < budget) begin
      step();
      k++;
    end
    check({name, "_accepted"}, 32'(accepted), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0;
    int p0;

    // Reset state
    step(3);
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_push_en", fq_push_en, 1'b0);

    // Release: one BOOT cycle, then requests start at RESET_PC
    @(posedge clk); #1;
    rst      = 1'b1;
    fetch_en = 1'b1;
    @(negedge clk);
    check("boot_req_valid", imem_req_valid, 1'b0);
    @(negedge clk);
    check("first_req_valid", imem_req_valid, 1'b1);
    check("first_addr", imem_req_addr, RST_PC);

    // Streaming with 1-cycle memory: 0x00..0x1C, push two cycles after accept
    step();
    lat     = 1;
    lat_chk = 1'b1;
    expect_pcs(32'h0, 8);
    limit   = accepted + 8;
    wait_drain("stream", 200);
    lat_chk = 1'b0;

    // Ready held low: request and address hold steady
    repeat (5) begin
      @(negedge clk);
      check("stall_req_valid", imem_req_valid, 1'b1);
      check("stall_addr", imem_req_addr, 32'h20);
    end

    // Fetch queue full: only the credit limit of requests goes out, no pushes
    step();
    fq_full = 1'b1;
    expect_pcs(32'h20, 8);
    a0    = accepted;
    p0    = pushes;
    limit = accepted + 8;
    step(10);
    check("full_accepted", 32'(accepted - a0), 32'd2);
    check("full_no_push", 32'(pushes - p0), 32'd0);
    fq_full = 1'b0;
    wait_drain("full_release", 200);

    // Redirect with two in flight; first response coincides with the redirect
    step();
    lat   = 2;
    a0    = accepted;
    limit = a0 + 2;
    expect_pcs(32'h100, 4);
    step();
    wait_accepted("pre_redirect", a0 + 2, 20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    check("redirect_gate", imem_req_valid, 1'b0);
    step();
    redirect_valid = 1'b0;
    lat   = 1;
    limit = accepted + 4;
    @(negedge clk);
    check("redirect_addr", imem_req_addr, 32'h100);
    wait_drain("redirect", 200);

    // Wrap around the top of the address space
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF9;
    expect_pcs(32'hFFFF_FFF8, 4);
    step();
    redirect_valid = 1'b0;
    limit = accepted + 4;
    @(negedge clk);
    check("wrap_start_addr", imem_req_addr, 32'hFFFF_FFF8);
    wait_drain("wrap", 200);
    @(negedge clk);
    check("wrap_next_addr", imem_req_addr, 32'h8);

    // Reset with two requests in flight: their responses never appear
    step();
    lat   = 3;
    a0    = accepted;
    limit = a0 + 2;
    step();
    wait_accepted("pre_reset", a0 + 2, 20);
    rst = 1'b0;
    step();
    @(negedge clk);
    check("midrst_req_valid", imem_req_valid, 1'b0);
    check("midrst_push_en", fq_push_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_boot_valid", imem_req_valid, 1'b0);
    @(negedge clk);
    check("midrst_req_valid_after", imem_req_valid, 1'b1);
    check("midrst_addr", imem_req_addr, RST_PC);
    step(10);
    check("late_resp_absent", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
